// File: rtl/cascade_and_arbiter_if.sv
// rtl/cascade_and_arbiter_if.sv - client-side request/grant bus of the cascade-AND arbiter
interface cascade_and_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  logic [N-1:0]   req;
  logic [N*W-1:0] data_in;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic           result;
  logic           busy;

  modport master (
    output req, data_in,
    input  gnt, done, result, busy
  );

  modport slave (
    input  req, data_in,
    output gnt, done, result, busy
  );
endinterface

// File: rtl/cascade_and_arbiter.sv
// rtl/cascade_and_arbiter.sv - round-robin sequencer sharing one cascade-AND unit among N clients
// Optional CASCADE_ARB_STATS_EN adds txn_count / and_hits counters.
module cascade_and_arbiter #(
  parameter int N      = 4,
  parameter int W      = 8,
  parameter int SETTLE = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cascade_and_arbiter_if.slave  cli,
  output logic [W-1:0]          and_x,
  input  logic                  and_y
`ifdef CASCADE_ARB_STATS_EN
  ,
  output logic [15:0]           txn_count,
  output logic [15:0]           and_hits
`endif
);

  localparam int LW = $clog2(N);

  typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, RESPOND} state_t;

  state_t         state, state_nx;
  logic [3:0]     cnt;
  logic [LW-1:0]  last;
  logic [LW-1:0]  win_idx;
  logic           win_valid;
  int             cand;
  logic [N-1:0]   gnt_q;
  logic [N-1:0]   done_q;
  logic           result_q;

  // Search starts one past the previous winner so every waiting client is served per sweep.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(last) + k) % N;
      if (!win_valid && cli.req[cand]) begin
        win_valid = 1'b1;
        win_idx   = LW'(cand);
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (win_valid) state_nx = DRIVE;
      DRIVE:   if (cnt == 4'd0) state_nx = CAPTURE;
      CAPTURE: state_nx = RESPOND;
      RESPOND: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      and_x    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      result_q <= 1'b0;
      cnt      <= 4'd0;
      last     <= LW'(N - 1);
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            gnt_q          <= '0;
            gnt_q[win_idx] <= 1'b1;
            and_x          <= cli.data_in[int'(win_idx)*W +: W];
            last           <= win_idx;
            cnt            <= 4'(SETTLE - 1);
          end
        end
        DRIVE: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        CAPTURE: begin
          result_q <= and_y;
          done_q   <= gnt_q;
        end
        RESPOND: begin
          done_q <= '0;
          gnt_q  <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef CASCADE_ARB_STATS_EN
  logic [15:0] txn_cnt;
  logic [15:0] hit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_cnt <= 16'd0;
      hit_cnt <= 16'd0;
    end else if (state == CAPTURE) begin
      txn_cnt <= txn_cnt + 16'd1;
      if (and_y) hit_cnt <= hit_cnt + 16'd1;
    end
  end

  assign txn_count = txn_cnt;
  assign and_hits  = hit_cnt;
`endif

  assign cli.gnt    = gnt_q;
  assign cli.done   = done_q;
  assign cli.result = result_q;
  assign cli.busy   = (state != IDLE);

endmodule

// File: tb/tb_cascade_and_arbiter.sv
// tb/tb_cascade_and_arbiter.sv - scoreboard bench for cascade_and_arbiter
module tb_cascade_and_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] and_x;
  logic         and_y;
`ifdef CASCADE_ARB_STATS_EN
  logic [15:0]  txn_count;
  logic [15:0]  and_hits;
`endif

  int tests = 0;
  int fails = 0;
  int exp_idx[$];
  logic exp_res[$];

  cascade_and_arbiter_if #(.N(N), .W(W)) cli ();

  cascade_and_arbiter #(.N(N), .W(W), .SETTLE(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cli       (cli),
    .and_x     (and_x),
    .and_y     (and_y)
`ifdef CASCADE_ARB_STATS_EN
    ,
    .txn_count (txn_count),
    .and_hits  (and_hits)
`endif
  );

  // Behavioural stand-in for the shared cascade-AND unit.
  assign and_y = &and_x;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (cli.done != '0) begin
      if (exp_idx.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=%b expected none", cli.done);
      end else begin
        automatic int   i = exp_idx.pop_front();
        automatic logic r = exp_res.pop_front();
        check("done_onehot", 32'(cli.done), 32'(1) << i);
        check("result", 32'(cli.result), 32'(r));
      end
    end
  end

  task automatic set_op(input int i, input logic [W-1:0] v);
    cli.data_in[i*W +: W] = v;
  endtask

  task automatic wait_done(input int i);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (cli.done[i]) return;
    end
    check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_any_done(output logic [N-1:0] d);
    d = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (cli.done != '0) begin
        d = cli.done;
        return;
      end
    end
    check("any_done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [N-1:0] d;
    rst_n       = 1'b0;
    cli.req     = '0;
    cli.data_in = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_gnt", 32'(cli.gnt), 32'd0);
    check("rst_done", 32'(cli.done), 32'd0);
    check("rst_busy", 32'(cli.busy), 32'd0);
    check("rst_and_x", 32'(and_x), 32'd0);
    check("rst_result", 32'(cli.result), 32'd0);

    // Single request, cycle-exact latency.
    exp_idx.push_back(0); exp_res.push_back(1'b1);
    set_op(0, 8'hFF);
    cli.req = 4'b0001;
    @(negedge clk);
    check("t1_gnt", 32'(cli.gnt), 32'h1);
    check("t1_and_x", 32'(and_x), 32'hFF);
    check("t1_busy", 32'(cli.busy), 32'd1);
    @(negedge clk);
    check("t1_done_early1", 32'(cli.done), 32'd0);
    @(negedge clk);
    check("t1_done_early2", 32'(cli.done), 32'd0);
    @(negedge clk);
    check("t1_done_on_time", 32'(cli.done), 32'h1);
    cli.req = '0;
    @(negedge clk);
    check("t1_done_cleared", 32'(cli.done), 32'd0);
    check("t1_busy_low", 32'(cli.busy), 32'd0);
    check("t1_gnt_low", 32'(cli.gnt), 32'd0);

    // Zero operand on requester 2.
    exp_idx.push_back(2); exp_res.push_back(1'b0);
    set_op(2, 8'hFE);
    cli.req = 4'b0100;
    wait_done(2);
    cli.req = '0;
    @(negedge clk);
    check("t2_pulse_width", 32'(cli.done), 32'd0);
    check("t2_result_held", 32'(cli.result), 32'd0);

    // Operand stability: later data_in changes are ignored.
    exp_idx.push_back(1); exp_res.push_back(1'b0);
    set_op(1, 8'hAA);
    cli.req = 4'b0010;
    @(negedge clk);
    check("t3_gnt", 32'(cli.gnt), 32'h2);
    check("t3_and_x_latched", 32'(and_x), 32'hAA);
    set_op(1, 8'hFF);
    @(negedge clk);
    check("t3_and_x_stable", 32'(and_x), 32'hAA);
    wait_done(1);
    cli.req = '0;
    repeat (2) @(negedge clk);
    check("t3_and_x_held_idle", 32'(and_x), 32'hAA);
    check("t3_busy_low", 32'(cli.busy), 32'd0);

    // Async reset mid-DRIVE: no done, outputs clear before any clock edge.
    set_op(3, 8'hFF);
    cli.req = 4'b1000;
    @(negedge clk);
    check("t4_gnt", 32'(cli.gnt), 32'h8);
    #2 rst_n = 1'b0;
    #1;
    check("t4_rst_gnt", 32'(cli.gnt), 32'd0);
    check("t4_rst_done", 32'(cli.done), 32'd0);
    check("t4_rst_busy", 32'(cli.busy), 32'd0);
    check("t4_rst_and_x", 32'(and_x), 32'd0);
    cli.req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Round robin with all four requesting; order must be 0,1,2,3,0.
    set_op(0, 8'hFF); set_op(1, 8'h7F); set_op(2, 8'hFF); set_op(3, 8'hFE);
    exp_idx.push_back(0); exp_res.push_back(1'b1);
    exp_idx.push_back(1); exp_res.push_back(1'b0);
    exp_idx.push_back(2); exp_res.push_back(1'b1);
    exp_idx.push_back(3); exp_res.push_back(1'b0);
    exp_idx.push_back(0); exp_res.push_back(1'b1);
    cli.req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_any_done(d);
      if (n == 4) begin
        cli.req = '0;
      end else begin
        cli.req = cli.req & ~d;
        @(negedge clk);
        cli.req = cli.req | d;
      end
    end
    repeat (8) @(negedge clk);
    check("rr_idle", 32'(cli.busy), 32'd0);

`ifdef CASCADE_ARB_STATS_EN
    check("stats_txn", 32'(txn_count), 32'd5);
    check("stats_hits", 32'(and_hits), 32'd3);
    force dut.txn_cnt = 16'hFFFF;
    #1 release dut.txn_cnt;
    exp_idx.push_back(1); exp_res.push_back(1'b0);
    cli.req = 4'b0010;
    wait_done(1);
    cli.req = '0;
    @(negedge clk);
    check("stats_wrap", 32'(txn_count), 32'd0);
    check("stats_hits_kept", 32'(and_hits), 32'd3);
`endif

    check("scoreboard_empty", 32'(exp_idx.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
